set_readback: RTL and testbench

// - Read side of the settings register. Answers CPU reads of the settings window with the live slow-device

---
 rtl/set_readback_if.sv | 28 ++
 rtl/set_readback.sv | 156 +++++++++++++++
 tb/tb_set_readback.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/set_readback_if.sv
// CPU-side bus signals of the settings read window: request qualifiers in,
// read data / enable / acknowledge out.
interface set_readback_if;
  logic        BACT;
  logic        SetCSRD;
  logic [1:0]  A;
  logic [15:0] D;
  logic        DOE;
  logic        RDACK;

  modport master (
    output BACT,
    output SetCSRD,
    output A,
    input  D,
    input  DOE,
    input  RDACK
  );

  modport slave (
    input  BACT,
    input  SetCSRD,
    input  A,
    output D,
    output DOE,
    output RDACK
  );
endinterface

// File: rtl/set_readback.sv
// Read side of the settings register: snapshots the live slow-device setup on a
// request, inserts wait states, then drives the selected word until the bus cycle ends.
module set_readback #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [3:0]  VERSION     = 4'h1,
  parameter logic [15:0] ID          = 16'h5753
) (
  input  logic            CLK,
  input  logic            nPOR,
  input  logic            SetWR,
  input  logic [3:0]      SlowTimeout,
  input  logic [6:0]      SlowFlags,
  set_readback_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic       NO_WAIT   = (WAIT_STATES == 0);

  state_t      state;
  state_t      stateNext;
  logic [3:0]  waitCnt;
  logic [3:0]  cntNext;

  logic        capture;
  logic        enterDrive;
  logic        leaveDrive;
  logic        useLive;

  logic [1:0]  snapA;
  logic [3:0]  snapTimeout;
  logic [6:0]  snapFlags;

  logic [1:0]  selA;
  logic [3:0]  selTimeout;
  logic [6:0]  selFlags;
  logic [15:0] wordNext;

  logic        changed;
  logic [15:0] rdCount;
  logic [15:0] dReg;
  logic        doeReg;
  logic        rdackReg;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = waitCnt;
    capture    = 1'b0;
    enterDrive = 1'b0;
    leaveDrive = 1'b0;
    useLive    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.BACT && bus.SetCSRD) begin
          capture = 1'b1;
          if (NO_WAIT) begin
            stateNext  = DRIVE;
            enterDrive = 1'b1;
            useLive    = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.BACT) begin
          stateNext = IDLE;
        end else if (waitCnt == '0) begin
          stateNext  = DRIVE;
          enterDrive = 1'b1;
        end else begin
          cntNext = waitCnt - 4'd1;
        end
      end
      DRIVE: begin
        if (!bus.BACT) begin
          stateNext  = IDLE;
          leaveDrive = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // With no wait states the snapshot loads on the same edge D is registered,
  // so the word is built from the live inputs in that case.
  always_comb begin
    selA       = useLive ? bus.A       : snapA;
    selTimeout = useLive ? SlowTimeout : snapTimeout;
    selFlags   = useLive ? SlowFlags   : snapFlags;
    case (selA)
      2'd0:    wordNext = {VERSION, selTimeout, selFlags, changed};
      2'd1:    wordNext = rdCount;
      2'd2:    wordNext = ID;
      default: wordNext = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      snapA       <= '0;
      snapTimeout <= '0;
      snapFlags   <= '0;
      changed     <= 1'b0;
      rdCount     <= '0;
      dReg        <= '0;
      doeReg      <= 1'b0;
      rdackReg    <= 1'b0;
    end else begin
      if (capture) begin
        snapA       <= bus.A;
        snapTimeout <= SlowTimeout;
        snapFlags   <= SlowFlags;
      end

      if (enterDrive) begin
        dReg     <= wordNext;
        doeReg   <= 1'b1;
        rdackReg <= 1'b1;
        rdCount  <= rdCount + 16'd1;
      end else if (leaveDrive) begin
        dReg     <= '0;
        doeReg   <= 1'b0;
        rdackReg <= 1'b0;
      end

      // A write landing on the clearing edge must not be lost.
      if (SetWR) begin
        changed <= 1'b1;
      end else if (enterDrive && (selA == 2'd0)) begin
        changed <= 1'b0;
      end
    end
  end

  assign bus.D     = dReg;
  assign bus.DOE   = doeReg;
  assign bus.RDACK = rdackReg;

endmodule

// File: tb/tb_set_readback.sv
// Directed bench for set_readback: table of single reads plus hand-written
// abort, coincident-write, counter-wrap and mid-cycle reset sequences.
module tb_set_readback;

  localparam int unsigned WS = 2;

  logic        CLK;
  logic        nPOR;
  logic        SetWR;
  logic [3:0]  SlowTimeout;
  logic [6:0]  SlowFlags;

  set_readback_if bus ();

  set_readback #(
    .WAIT_STATES (WS),
    .VERSION     (4'h1),
    .ID          (16'h5753)
  ) dut (
    .CLK         (CLK),
    .nPOR        (nPOR),
    .SetWR       (SetWR),
    .SlowTimeout (SlowTimeout),
    .SlowFlags   (SlowFlags),
    .bus         (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [1:0]  a;
    logic [3:0]  tmo;
    logic [6:0]  flg;
    logic        wrFirst;
    logic [15:0] expD;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic pulseWr();
    @(negedge CLK);
    SetWR = 1'b1;
    @(negedge CLK);
    SetWR = 1'b0;
  endtask

  // Full read bus cycle: request, bounded wait for RDACK, hold one cycle with
  // SetCSRD/A disturbed, then end the cycle and check the outputs return to 0.
  task automatic doRead(input logic [1:0] a, input string nm, output logic [15:0] d);
    int lat;
    lat = 0;
    @(negedge CLK);
    bus.BACT    = 1'b1;
    bus.SetCSRD = 1'b1;
    bus.A       = a;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!bus.RDACK && lat < 20);
    chk({nm, " latency"}, lat, WS + 1);
    chk({nm, " DOE"}, {31'd0, bus.DOE}, 32'd1);
    d = bus.D;
    @(negedge CLK);
    bus.SetCSRD = 1'b0;
    bus.A       = ~a;
    @(posedge CLK);
    #1;
    chk({nm, " hold D"}, {16'd0, bus.D}, {16'd0, d});
    chk({nm, " hold RDACK"}, {31'd0, bus.RDACK}, 32'd1);
    @(negedge CLK);
    bus.BACT = 1'b0;
    @(posedge CLK);
    #1;
    chk({nm, " end D/DOE/RDACK"}, {15'd0, bus.D, bus.DOE, bus.RDACK}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        sawAck;

    vecs[0] = '{2'd0, 4'hF, 7'h3B, 1'b0, 16'h1F76};
    vecs[1] = '{2'd0, 4'hF, 7'h3B, 1'b1, 16'h1F77};
    vecs[2] = '{2'd0, 4'hF, 7'h3B, 1'b0, 16'h1F76};
    vecs[3] = '{2'd1, 4'hF, 7'h3B, 1'b0, 16'h0003};
    vecs[4] = '{2'd2, 4'hF, 7'h3B, 1'b0, 16'h5753};
    vecs[5] = '{2'd3, 4'hF, 7'h3B, 1'b0, 16'h0000};
    vecs[6] = '{2'd0, 4'h3, 7'h55, 1'b1, 16'h13AB};
    vecs[7] = '{2'd1, 4'h3, 7'h55, 1'b0, 16'h0007};
    vecs[8] = '{2'd0, 4'h0, 7'h00, 1'b0, 16'h1000};

    nPOR        = 1'b0;
    SetWR       = 1'b0;
    SlowTimeout = 4'hF;
    SlowFlags   = 7'h3B;
    bus.BACT    = 1'b0;
    bus.SetCSRD = 1'b0;
    bus.A       = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset D/DOE/RDACK", {15'd0, bus.D, bus.DOE, bus.RDACK}, 32'd0);
    @(negedge CLK);
    nPOR = 1'b1;

    for (int i = 0; i < 9; i++) begin
      SlowTimeout = vecs[i].tmo;
      SlowFlags   = vecs[i].flg;
      if (vecs[i].wrFirst) pulseWr();
      doRead(vecs[i].a, $sformatf("vec%0d", i), d);
      chk($sformatf("vec%0d D", i), {16'd0, d}, {16'd0, vecs[i].expD});
    end

    // Abort in WAIT: RdCount stays 9, Changed stays set.
    SlowTimeout = 4'hF;
    SlowFlags   = 7'h3B;
    pulseWr();
    @(negedge CLK);
    bus.BACT    = 1'b1;
    bus.SetCSRD = 1'b1;
    bus.A       = 2'd0;
    @(negedge CLK);
    bus.BACT    = 1'b0;
    bus.SetCSRD = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      if (bus.RDACK || bus.DOE) sawAck = 1'b1;
    end
    chk("abort no RDACK/DOE", {31'd0, sawAck}, 32'd0);
    doRead(2'd1, "abort count", d);
    chk("abort count D", {16'd0, d}, 32'h0009);
    doRead(2'd0, "abort changed", d);
    chk("abort changed D", {16'd0, d}, 32'h1F77);

    // SetWR on the DRIVE-entry edge of a word-0 read.
    @(negedge CLK);
    bus.BACT    = 1'b1;
    bus.SetCSRD = 1'b1;
    bus.A       = 2'd0;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    chk("coinc RDACK before entry", {31'd0, bus.RDACK}, 32'd0);
    @(negedge CLK);
    SetWR = 1'b1;
    @(posedge CLK);
    #1;
    chk("coinc RDACK at entry", {31'd0, bus.RDACK}, 32'd1);
    chk("coinc D", {16'd0, bus.D}, 32'h1F76);
    @(negedge CLK);
    SetWR       = 1'b0;
    bus.BACT    = 1'b0;
    bus.SetCSRD = 1'b0;
    @(posedge CLK);
    #1;
    chk("coinc end DOE", {31'd0, bus.DOE}, 32'd0);
    doRead(2'd0, "coinc after", d);
    chk("coinc after D", {16'd0, d}, 32'h1F77);
    doRead(2'd1, "coinc count", d);
    chk("coinc count D", {16'd0, d}, 32'h000D);

    // RdCount wrap, starting from a preloaded all-ones count.
    @(negedge CLK);
    force dut.rdCount = 16'hFFFF;
    @(negedge CLK);
    release dut.rdCount;
    doRead(2'd1, "wrap first", d);
    chk("wrap first D", {16'd0, d}, 32'h0000FFFF);
    doRead(2'd1, "wrap second", d);
    chk("wrap second D", {16'd0, d}, 32'h00000000);

    // Asynchronous reset in the middle of DRIVE.
    pulseWr();
    @(negedge CLK);
    bus.BACT    = 1'b1;
    bus.SetCSRD = 1'b1;
    bus.A       = 2'd2;
    repeat (3) @(posedge CLK);
    #1;
    chk("midrst DRIVE reached", {15'd0, bus.D, bus.DOE, bus.RDACK}, {15'd0, 16'h5753, 2'b11});
    #2;
    nPOR = 1'b0;
    #1;
    chk("midrst async clear", {15'd0, bus.D, bus.DOE, bus.RDACK}, 32'd0);
    bus.BACT    = 1'b0;
    bus.SetCSRD = 1'b0;
    @(negedge CLK);
    nPOR = 1'b1;
    doRead(2'd1, "midrst count", d);
    chk("midrst count D", {16'd0, d}, 32'h0000);
    doRead(2'd0, "midrst changed", d);
    chk("midrst changed D", {16'd0, d}, 32'h1F76);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
